// File: rtl/spi_cmd_controller.sv
// -----------------------------------------------------------------------------
// spi_cmd_controller
//
// SPI controller (mode 0, MSB first) that serialises command bytes for the
// spi_client receiver. Upstream logic pushes bytes through a valid/ready
// handshake into a small byte FIFO. The controller derives cs, spi_clk and
// mosi from clk with an integer divider. Bytes that are already queued when
// the current byte finishes are chained into the same cs-low frame. The
// receiver decodes one command per byte.
//
// Parameters
//   CLK_DIV     clk cycles per spi_clk half-period (>= 2)
//   FIFO_DEPTH  byte FIFO entries (power of 2, >= 2)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset (flushes FIFO, aborts frame)
//   tx_data    in   byte to send
//   tx_valid   in   tx_data valid
//   tx_ready   out  FIFO can accept a byte (FIFO not full)
//   spi_clk    out  SPI clock, idle low
//   mosi       out  serial data, changes only while spi_clk is low
//   cs         out  chip select, active low
//   byte_done  out  one-cycle pulse when a byte's last spi_clk high phase ends
//   busy       out  state machine active or FIFO non-empty
// -----------------------------------------------------------------------------
module spi_cmd_controller #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       spi_clk,
  output logic       mosi,
  output logic       cs,
  output logic       byte_done,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Byte FIFO. Pointers carry one extra wrap bit so full and empty can be told
  // apart without a separate occupancy counter.
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push       = tx_valid && !fifo_full;
  assign head       = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_t       state_reg,     state_next;
  logic [DW-1:0] div_cnt_reg,  div_cnt_next;
  logic [2:0]   bit_cnt_reg,   bit_cnt_next;
  logic [7:0]   shreg_reg,     shreg_next;
  logic         cs_reg,        cs_next;
  logic         spi_clk_reg,   spi_clk_next;
  logic         mosi_reg,      mosi_next;
  logic         byte_done_reg, byte_done_next;
  logic         tick;

  assign tick = (div_cnt_reg == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shreg_reg     <= '0;
      cs_reg        <= 1'b1;
      spi_clk_reg   <= 1'b0;
      mosi_reg      <= 1'b0;
      byte_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shreg_reg     <= shreg_next;
      cs_reg        <= cs_next;
      spi_clk_reg   <= spi_clk_next;
      mosi_reg      <= mosi_next;
      byte_done_reg <= byte_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shreg_next     = shreg_reg;
    cs_next        = cs_reg;
    spi_clk_next   = spi_clk_reg;
    mosi_next      = mosi_reg;
    byte_done_next = 1'b0;
    pop            = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          shreg_next   = head;
          bit_cnt_next = 3'd0;
          cs_next      = 1'b0;
          spi_clk_next = 1'b0;
          mosi_next    = head[7];
          state_next   = SETUP;
        end
      end

      SETUP: begin
        if (tick) begin
          spi_clk_next = 1'b1;
          state_next   = HIGH;
        end
      end

      HIGH: begin
        if (tick) begin
          spi_clk_next = 1'b0;
          if (bit_cnt_reg != 3'd7) begin
            // shreg[7] always holds the bit currently on the wire
            shreg_next   = {shreg_reg[6:0], 1'b0};
            mosi_next    = shreg_reg[6];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            state_next   = LOW;
          end else begin
            byte_done_next = 1'b1;
            // Only bytes already in the FIFO at this tick join the frame
            if (!fifo_empty) begin
              pop          = 1'b1;
              shreg_next   = head;
              mosi_next    = head[7];
              bit_cnt_next = 3'd0;
              state_next   = LOW;
            end else begin
              state_next   = HOLD;
            end
          end
        end
      end

      LOW: begin
        if (tick) begin
          spi_clk_next = 1'b1;
          state_next   = HIGH;
        end
      end

      HOLD: begin
        if (tick) begin
          cs_next    = 1'b1;
          mosi_next  = 1'b0;
          state_next = GAP;
        end
      end

      GAP: begin
        // cs stays high for at least CLK_DIV cycles between frames
        if (tick) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Divider restarts on every state change and stays parked while idle
    if ((state_next != state_reg) || (state_reg == IDLE)) begin
      div_cnt_next = '0;
    end else begin
      div_cnt_next = div_cnt_reg + DW'(1);
    end
  end

  assign tx_ready  = !fifo_full;
  assign cs        = cs_reg;
  assign spi_clk   = spi_clk_reg;
  assign mosi      = mosi_reg;
  assign byte_done = byte_done_reg;
  assign busy      = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_cmd_controller.sv
module tb_spi_cmd_controller;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       spi_clk;
  logic       mosi;
  logic       cs;
  logic       byte_done;
  logic       busy;

  always #5 clk = ~clk;

  spi_cmd_controller #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .spi_clk  (spi_clk),
    .mosi     (mosi),
    .cs       (cs),
    .byte_done(byte_done),
    .busy     (busy)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard: bytes accepted by the DUT, in the order they must appear on mosi
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lim);
    tests++;
    if (act < lim) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected >= %0d (t=%0t)", name, act, lim, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: acts as the SPI receiver. Samples on the falling clk edge,
  // decodes bytes at spi_clk rises and checks frame-level timing rules.
  // ---------------------------------------------------------------------------
  logic       prev_cs   = 1'b1;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;
  logic [7:0] shift_in  = '0;
  int nbits = 0, frame_len = 0, frame_bytes = 0, frame_rises = 0, frame_dones = 0;
  int gap_len = 0;
  bit in_frame = 0, gap_valid = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 0;
      gap_valid = 0;
      nbits     = 0;
    end else begin
      if (mosi !== prev_mosi && spi_clk === 1'b1) begin
        chk("mosi_change_while_sclk_high", 1, 0);
      end
      if (!cs) begin
        if (prev_cs) begin
          in_frame    = 1;
          frame_len   = 0;
          frame_bytes = 0;
          frame_rises = 0;
          frame_dones = 0;
          nbits       = 0;
          if (gap_valid) chk_ge("cs_high_gap", gap_len, CLK_DIV);
        end
        frame_len++;
        if (spi_clk && !prev_sclk) begin
          frame_rises++;
          chk("mosi_stable_at_rise", mosi, prev_mosi);
          shift_in = {shift_in[6:0], mosi};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            frame_bytes++;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("[TB] FAIL rx_byte: got 0x%02h, expected no byte", shift_in);
            end else begin
              logic [7:0] e;
              e = exp_q.pop_front();
              chk("rx_byte", shift_in, e);
              $display("[TB] rx byte 0x%02h (expected 0x%02h)", shift_in, e);
            end
          end
        end
        if (byte_done && in_frame) frame_dones++;
      end else begin
        if (!prev_cs && in_frame) begin
          chk("frame_cs_low_cycles", frame_len, CLK_DIV * (1 + 16 * frame_bytes));
          chk("frame_sclk_rises", frame_rises, 8 * frame_bytes);
          chk("frame_byte_done", frame_dones, frame_bytes);
          chk("frame_partial_bits", nbits, 0);
          chk("sclk_low_at_cs_rise", spi_clk, 0);
          $display("[TB] frame: %0d bytes, cs low %0d cycles", frame_bytes, frame_len);
          in_frame  = 0;
          gap_valid = 1;
          gap_len   = 0;
        end
        gap_len++;
      end
    end
    prev_cs   = cs;
    prev_sclk = spi_clk;
    prev_mosi = mosi;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves tx_valid high so callers can chain back-to-back pushes
  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      step();
      n++;
    end
    chk("push_ready", tx_ready, 1);
    if (tx_ready) begin
      exp_q.push_back(b);
      $display("[TB] push 0x%02h", b);
      step();
    end
  endtask

  task automatic wait_cs(input logic val, input int budget);
    int n;
    n = 0;
    while (cs !== val && n < budget) begin
      step();
      n++;
    end
    chk("wait_cs", cs, val);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] burst [6];
    int rises;
    logic prev;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) step();
    chk("reset_cs", cs, 1);
    chk("reset_sclk", spi_clk, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_byte_done", byte_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tx_ready", tx_ready, 1);
    rst = 1'b0;
    repeat (2) step();

    // Single byte from idle: latency, frame length and busy release
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    exp_q.push_back(8'hA5);
    $display("[TB] push 0xa5");
    step();
    tx_valid = 1'b0;
    chk("cs_before_latency", cs, 1);
    step();
    chk("cs_low_at_n_plus_2", cs, 0);
    wait_cs(1'b1, 200);
    chk("busy_during_gap", busy, 1);
    repeat (CLK_DIV) step();
    chk("busy_after_gap", busy, 0);
    repeat (3) step();

    // Three back-to-back bytes -> one 196-cycle frame
    push(8'h3C);
    push(8'h81);
    push(8'hFF);
    tx_valid = 1'b0;
    drain(1000);

    // Loopback command sequence
    push(8'h12);
    push(8'hEF);
    tx_valid = 1'b0;
    drain(1000);

    // FIFO fill while a frame is in progress
    push(8'h11);
    tx_valid = 1'b0;
    wait_cs(1'b0, 20);
    for (int i = 0; i < 6; i++) burst[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      push(burst[i]);
      if (i == 3) chk("tx_ready_low_when_full", tx_ready, 0);
    end
    tx_valid = 1'b0;
    drain(3000);

    // Reset mid-byte: in-flight byte and queued byte are both discarded
    push(8'hC3);
    push(8'h77);
    tx_valid = 1'b0;
    rises = 0;
    prev  = spi_clk;
    for (int n = 0; n < 400 && rises < 3; n++) begin
      step();
      if (spi_clk && !prev) rises++;
      prev = spi_clk;
    end
    chk("rises_before_reset", rises, 3);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    chk("midrst_cs", cs, 1);
    chk("midrst_sclk", spi_clk, 0);
    chk("midrst_mosi", mosi, 0);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_busy", busy, 0);
    repeat (2) step();
    push(8'h5A);
    tx_valid = 1'b0;
    drain(1000);

    // Push during GAP -> separate frame
    push(8'h01);
    tx_valid = 1'b0;
    wait_cs(1'b0, 20);
    wait_cs(1'b1, 200);
    push(8'h02);
    tx_valid = 1'b0;
    drain(1000);

    // Randomised traffic with random spacing (hits chain and no-chain cases)
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        tx_valid = 1'b0;
        repeat ($urandom_range(0, 80)) step();
      end
    end
    tx_valid = 1'b0;
    drain(6000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
